// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: valid/ready request channel in, valid/ready result channel out.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       operation;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, operation, left, right, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, operation, left, right, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked shift/compare/add ALU; latency 1, or 1+s for shifts unless ALU_SEQ_BARREL_EN is defined.
// Result is held in DONE until out_ready; one bubble per transaction, no accept while busy.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_SRL  = 3'd0;
  localparam logic [2:0] OP_SRA  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;

  logic [SHW-1:0]   amt;
  logic             lt_u, lt_s;
  logic             is_shift, go_shift;
  logic [WIDTH-1:0] srl_res, sra_res, sll_res;
  logic [WIDTH-1:0] acc_res;

  assign amt      = bus.right[SHW-1:0];
  assign is_shift = (bus.operation == OP_SRL) || (bus.operation == OP_SRA) ||
                    (bus.operation == OP_SLL);

  // Signed compare from the MSBs: differing signs decide directly, else unsigned order holds.
  assign lt_u = bus.left < bus.right;
  assign lt_s = (bus.left[WIDTH-1] ^ bus.right[WIDTH-1]) ? bus.left[WIDTH-1] : lt_u;

`ifdef ALU_SEQ_BARREL_EN
  assign srl_res  = bus.left >> amt;
  assign sra_res  = srl_res | (bus.left[WIDTH-1] ? ~({WIDTH{1'b1}} >> amt) : '0);
  assign sll_res  = bus.left << amt;
  assign go_shift = 1'b0;
`else
  // Only the zero-amount shift completes at accept; anything else iterates in SHIFT.
  assign srl_res  = bus.left;
  assign sra_res  = bus.left;
  assign sll_res  = bus.left;
  assign go_shift = is_shift && (amt != '0);
`endif

  always_comb begin
    acc_res = '0;
    case (bus.operation)
      OP_SRL:  acc_res = srl_res;
      OP_SRA:  acc_res = sra_res;
      OP_SLT:  acc_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: acc_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_SLL:  acc_res = sll_res;
      OP_ADD:  acc_res = bus.left + bus.right;
      OP_SUB:  acc_res = bus.left - bus.right;
      default: acc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.operation;
          fill_d = bus.left[WIDTH-1];
          if (go_shift) begin
            work_d  = bus.left;
            cnt_d   = amt;
            state_d = SHIFT;
          end else begin
            work_d  = acc_res;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SRA:  work_d = {fill_q, work_q[WIDTH-1:1]};
          OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
          default: work_d = {1'b0, work_q[WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = work_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): expected result/latency queued at issue, checked on out_valid.
module tb_alu_seq;
  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] exp_res[$];
  int          exp_lat[$];

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] l,
                                        input logic [31:0] r);
    int s;
    s = int'(r[4:0]);
    case (op)
      3'd0:    return l >> s;
      3'd1:    return $unsigned($signed(l) >>> s);
      3'd2:    return {31'b0, ($signed(l) < $signed(r))};
      3'd3:    return {31'b0, (l < r)};
      3'd4:    return l << s;
      3'd5:    return l + r;
      3'd6:    return l - r;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] r);
`ifdef ALU_SEQ_BARREL_EN
    return 1;
`else
    if ((op == 3'd0 || op == 3'd1 || op == 3'd4) && r[4:0] != 5'd0) return 1 + int'(r[4:0]);
    return 1;
`endif
  endfunction

  // Called at a negedge while in_ready is high; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.left      = l;
    bus.right     = r;
    exp_res.push_back(model(op, l, r));
    exp_lat.push_back(model_lat(op, r));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.operation = $urandom_range(0, 7);
    bus.left      = $urandom;
    bus.right     = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operation = 3'd0;
    bus.left      = '0;
    bus.right     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", bus.result); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_sra();
    int lat;
    logic [31:0] er;
    int el;
    issue(3'd1, 32'h8000_0000, 32'd4);
    wait_out(lat);
    er = exp_res.pop_front();
    el = exp_lat.pop_front();
    n_cmp++; if (lat != el) begin n_fail++; $display("FAIL sra_latency got=%0d want=%0d", lat, el); end
    n_cmp++; if (bus.result !== er) begin n_fail++; $display("FAIL sra_result got=%h want=%h", bus.result, er); end
    release_out();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sra_release got=%b%b want=01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_compare();
    int lat;
    logic [31:0] er;
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 3'd2 : 3'd3, 32'hFFFF_FFFF, 32'd1);
      wait_out(lat);
      er = exp_res.pop_front();
      void'(exp_lat.pop_front());
      n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL cmp%0d_latency got=%0d want=1", k, lat); end
      n_cmp++; if (bus.result !== er) begin n_fail++; $display("FAIL cmp%0d_result got=%h want=%h", k, bus.result, er); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] er;
    issue(3'd5, 32'hFFFF_FFFF, 32'd2);
    wait_out(lat);
    er = exp_res.pop_front();
    void'(exp_lat.pop_front());
    n_cmp++; if (er !== 32'h0000_0001) begin n_fail++; $display("FAIL bp_model got=%h want=00000001", er); end
    // Offer a competing op the whole time; it must be ignored while in_ready is low.
    bus.in_valid  = 1'b1;
    bus.operation = 3'd6;
    bus.left      = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (bus.result !== er || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold_c%0d got=%h/%b/%b want=%h/1/0", c, bus.result, bus.out_valid, bus.in_ready, er); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    release_out();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b%b want=01", bus.out_valid, bus.in_ready); end
    n_cmp++; if (bus.result !== er) begin n_fail++; $display("FAIL bp_ignored got=%h want=%h", bus.result, er); end
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'd1, 32'd31);
    repeat (8) @(negedge clk);
`ifndef ALU_SEQ_BARREL_EN
    n_cmp++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b%b want=10", bus.busy, bus.out_valid); end
`endif
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async got=%b%b want=00", bus.out_valid, bus.busy); end
    exp_res.delete();
    exp_lat.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0)
      begin n_fail++; $display("FAIL rmid_after got=%b%b/%h want=10/0", bus.in_ready, bus.out_valid, bus.result); end
  endtask

  task automatic test_zero_amount_op7();
    int lat;
    logic [31:0] er;
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 3'd0 : 3'd7, 32'hA5C3_0F96, 32'h0000_0020);
      wait_out(lat);
      er = exp_res.pop_front();
      void'(exp_lat.pop_front());
      n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL z%0d_latency got=%0d want=1", k, lat); end
      n_cmp++; if (bus.result !== er) begin n_fail++; $display("FAIL z%0d_result got=%h want=%h", k, bus.result, er); end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int el;
    logic [31:0] er, r;
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      r  = (n % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      if (n % 5 == 0) r[31] = ~r[31];
      issue(op, $urandom, r);
      wait_out(lat);
      er = exp_res.pop_front();
      el = exp_lat.pop_front();
      n_cmp++; if (lat != el) begin n_fail++; $display("FAIL b2b%0d_latency op=%0d got=%0d want=%0d", n, op, lat, el); end
      n_cmp++; if (bus.result !== er) begin n_fail++; $display("FAIL b2b%0d_result op=%0d got=%h want=%h", n, op, bus.result, er); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_compare();
    test_backpressure();
    test_reset_mid();
    test_zero_amount_op7();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
